serial_word_collector: RTL

SERIAL_WORD_COLLECTOR -- requirements
Module: serial_word_collector

---
 rtl/serial_word_collector.sv | 115 +++++++++++
 1 files changed

// File: rtl/serial_word_collector.sv
// Assembles LSB-first serial bits into 4-bit words and buffers them in a 2-entry FIFO.
// Outputs are registered; a full FIFO with no pop drops the new word and sets sticky overflow.
module serial_word_collector (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  input  logic       serial_valid,
  input  logic       start,
  output logic [3:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       overflow,
  output logic       busy
);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t          state_q, state_d;
  logic [1:0]      bit_cnt_q, bit_cnt_d;
  logic [3:0]      asm_reg_q, asm_reg_d;
  logic [1:0][3:0] mem_q, mem_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic [1:0]      count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [3:0]      data_out_q, data_out_d;
  logic            data_valid_q, data_valid_d;
  logic            busy_q, busy_d;

  logic            push;
  logic            push_ok;
  logic            pop;
  logic [3:0]      push_word;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    asm_reg_d    = asm_reg_q;
    mem_d        = mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    overflow_d   = overflow_q;
    push         = 1'b0;
    push_ok      = 1'b0;
    push_word    = {serial_in, asm_reg_q[2:0]};
    pop          = data_valid_q & data_ready;

    // A start bit always begins a fresh word, abandoning any partial one.
    if (serial_valid) begin
      if (start) begin
        asm_reg_d = {3'b000, serial_in};
        bit_cnt_d = 2'd1;
        state_d   = COLLECT;
      end else if (state_q == COLLECT) begin
        asm_reg_d[bit_cnt_q] = serial_in;
        bit_cnt_d            = bit_cnt_q + 2'd1;
        push                 = (bit_cnt_q == 2'd3);
      end
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    // When full, a concurrent pop frees exactly the slot wr_ptr points at.
    if (push) begin
      if ((count_q != 2'd2) || pop) begin
        push_ok         = 1'b1;
        mem_d[wr_ptr_q] = push_word;
        wr_ptr_d        = ~wr_ptr_q;
      end else begin
        overflow_d = 1'b1;
      end
    end

    count_d      = count_q + {1'b0, push_ok} - {1'b0, pop};
    data_valid_d = (count_d != 2'd0);
    data_out_d   = data_valid_d ? mem_d[rd_ptr_d] : 4'b0000;
    busy_d       = (state_d == COLLECT) && (bit_cnt_d != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 2'd0;
      asm_reg_q    <= 4'b0000;
      mem_q        <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      overflow_q   <= 1'b0;
      data_out_q   <= 4'b0000;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      asm_reg_q    <= asm_reg_d;
      mem_q        <= mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;

endmodule
